digit_scroller: RTL and testbench

DIGIT_SCROLLER -- requirements
Module: digit_scroller

---
 rtl/digit_scroller.sv | 112 +++++++++++
 tb/tb_digit_scroller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/digit_scroller.sv
// rtl/digit_scroller.sv - six-digit scrolling window over an eight-digit BCD message
// Optional SCROLL_GAP_EN: message period 10 with two blank positions after the message.
module digit_scroller #(
  parameter int TICK_DIV = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] msg_in,
  input  logic        run,
  input  logic        dir,
  output logic [23:0] digit_out,
  output logic [5:0]  blank_out,
  output logic        step,
  output logic        wrap
);

`ifdef SCROLL_GAP_EN
  localparam int LEN = 10;
  localparam int PW  = 4;
`else
  localparam int LEN = 8;
  localparam int PW  = 3;
`endif
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PTR_MAX = PW'(LEN - 1);
  localparam logic [CW-1:0] PRE_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {EMPTY, SHOW, SCROLL} state_t;

  state_t          state, state_nxt;
  logic [1:0]      rst_sync;
  logic            rst_i;
  logic [31:0]     buf_q;
  logic [PW-1:0]   ptr, ptr_nxt, pos;
  logic [CW-1:0]   presc;
  logic            tc, do_step, blk;
  logic [3:0]      nib;

  // Assert immediately, release two clean edges after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    tc        = (state == SCROLL) && (presc == PRE_MAX);
    do_step   = tc && !load;
    if (do_step) begin
      if (dir) ptr_nxt = (ptr == '0) ? PTR_MAX : ptr - 1'b1;
      else     ptr_nxt = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
    end
    case (state)
      EMPTY:   state_nxt = EMPTY;
      SHOW:    if (run)  state_nxt = SCROLL;
      SCROLL:  if (!run) state_nxt = SHOW;
      default: state_nxt = EMPTY;
    endcase
    if (load) state_nxt = run ? SCROLL : SHOW;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state <= EMPTY;
      buf_q <= '1;
      ptr   <= '0;
      presc <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= do_step;
      wrap  <= do_step && (ptr_nxt == '0);
      if (load) begin
        buf_q <= msg_in;
        ptr   <= '0;
        presc <= '0;
      end else begin
        ptr <= ptr_nxt;
        // Prescaler holds its value outside SCROLL so a pause resumes mid-interval.
        if (state == SCROLL) presc <= tc ? '0 : presc + 1'b1;
      end
    end
  end

  always_comb begin
    digit_out = '1;
    blank_out = '1;
    pos       = '0;
    nib       = 4'hF;
    blk       = 1'b1;
    if (state != EMPTY) begin
      for (int k = 0; k < 6; k++) begin
        pos = ptr + PW'(k);
`ifdef SCROLL_GAP_EN
        if (pos >= PW'(LEN)) pos = pos - PW'(LEN);
        nib = buf_q[{~pos[2:0], 2'b00} +: 4];
        blk = (nib > 4'd9) || pos[3];
`else
        nib = buf_q[{~pos[2:0], 2'b00} +: 4];
        blk = (nib > 4'd9);
`endif
        digit_out[(5-k)*4 +: 4] = blk ? 4'hF : nib;
        blank_out[5-k]          = blk;
      end
    end
  end

endmodule

// File: tb/tb_digit_scroller.sv
// tb/tb_digit_scroller.sv - scoreboard bench for digit_scroller with TICK_DIV=4
module tb_digit_scroller;
`ifdef SCROLL_GAP_EN
  localparam int LEN = 10;
`else
  localparam int LEN = 8;
`endif
  localparam logic [31:0] MSG = 32'h05182003;

  logic        clk = 1'b0, clk_en = 1'b0;
  logic        rst = 1'b0, load = 1'b0, run = 1'b0, dir = 1'b0;
  logic [31:0] msg_in = '0;
  logic [23:0] digit_out;
  logic [5:0]  blank_out;
  logic        step, wrap;

  typedef struct {
    logic [23:0] dig;
    logic [5:0]  blk;
    logic        wr;
  } exp_t;
  exp_t sb[$];

  int chk_cnt = 0, pass_cnt = 0;
  int n, cnt;

  digit_scroller #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .msg_in(msg_in), .run(run), .dir(dir),
    .digit_out(digit_out), .blank_out(blank_out), .step(step), .wrap(wrap)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic exp_t model(input int p, input logic [31:0] m, input logic wr);
    exp_t e;
    int q;
    logic [3:0] d;
    e.wr = wr;
    for (int k = 0; k < 6; k++) begin
      q = (p + k) % LEN;
      d = (q < 8) ? m[(7-q)*4 +: 4] : 4'hF;
      e.blk[5-k] = (q >= 8) || (d > 4'd9);
      e.dig[(5-k)*4 +: 4] = e.blk[5-k] ? 4'hF : d;
    end
    return e;
  endfunction

  // Waits for the next step pulse, then pops and compares one scoreboard entry.
  task automatic wait_step(input string tag, input int budget, output int cycles);
    exp_t e;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!step && cycles < budget);
    if (!step) check({tag, " timeout"}, 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " win"}, {8'h0, digit_out}, {8'h0, e.dig});
      check({tag, " blank"}, {26'h0, blank_out}, {26'h0, e.blk});
      check({tag, " wrap"}, {31'h0, wrap}, {31'h0, e.wr});
    end else begin
      check({tag, " sb empty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic count_steps(input int cycles, output int steps);
    steps = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (step) steps++;
    end
  endtask

  initial begin
    // Reset with the clock stopped must act at once.
    #5 rst = 1'b1;
    #1;
    check("rst blank", {26'h0, blank_out}, 32'h3F);
    check("rst digit", {8'h0, digit_out}, 32'hFFFFFF);
    check("rst step", {31'h0, step}, 32'd0);
    clk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Static display.
    msg_in = MSG; load = 1'b1;
    tick();
    load = 1'b0;
    check("show digit", {8'h0, digit_out}, 32'h051820);
    check("show blank", {26'h0, blank_out}, 32'h0);
    count_steps(20, cnt);
    check("show no step", cnt, 0);

    // Left scroll through one full period.
    run = 1'b1;
    for (int s = 1; s <= LEN; s++) sb.push_back(model(s % LEN, MSG, s == LEN));
    for (int s = 1; s <= LEN; s++) begin
      wait_step($sformatf("left%0d", s), 10, n);
      if (s > 1) check($sformatf("left%0d interval", s), n, 4);
      if (s == 1) check("left1 const", {8'h0, digit_out}, 32'h518200);
`ifdef SCROLL_GAP_EN
      if (s == 3) check("left3 const", {8'h0, digit_out}, 32'h82003F);
`endif
    end
    check("wrap window", {8'h0, digit_out}, 32'h051820);

    // Direction change mid-interval takes effect at the next step.
    dir = 1'b1;
    sb.push_back(model(LEN - 1, MSG, 1'b0));
    wait_step("right1", 10, n);
    check("right1 interval", n, 4);
`ifdef SCROLL_GAP_EN
    check("right1 hex5", {28'h0, digit_out[23:20]}, 32'hF);
`else
    check("right1 hex5", {28'h0, digit_out[23:20]}, 32'h3);
`endif

    // Pause two cycles after a step; prescaler resumes where it froze.
    repeat (2) tick();
    run = 1'b0;
    count_steps(10, cnt);
    check("pause no step", cnt, 0);
    run = 1'b1;
    sb.push_back(model(LEN - 2, MSG, 1'b0));
    wait_step("resume", 10, n);
    check("resume latency", n, 2);

    // Load exactly at terminal count suppresses the step.
    repeat (3) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    check("tc load step", {31'h0, step}, 32'd0);
    check("tc load wrap", {31'h0, wrap}, 32'd0);
    check("tc load ptr0", {8'h0, digit_out}, 32'h051820);
    sb.push_back(model(LEN - 1, MSG, 1'b0));
    wait_step("after tc load", 10, n);
    check("after tc load interval", n, 4);

    // Reset mid-scroll discards the message.
    rst = 1'b1;
    #1;
    check("midrst blank", {26'h0, blank_out}, 32'h3F);
    check("midrst digit", {8'h0, digit_out}, 32'hFFFFFF);
    tick();
    rst = 1'b0;
    count_steps(25, cnt);
    check("postrst no step", cnt, 0);
    check("postrst blank", {26'h0, blank_out}, 32'h3F);

    // Non-BCD nibbles are blanked.
    run = 1'b0; dir = 1'b0;
    msg_in = 32'h0A3B4C5D; load = 1'b1;
    tick();
    load = 1'b0;
    check("hex digit", {8'h0, digit_out}, 32'h0F3F4F);
    check("hex blank", {26'h0, blank_out}, 32'h15);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
